mem_port_arbiter: RTL and testbench

- Shares the core's single memory port between instruction fetch (IF) and the load/store unit (LSU).
- Uses a req/gnt/rvalid handshake with up to MAX_OUTSTANDING in-flight transactions.
- Routes in-order responses back to the owning requester through a small owner FIFO.
- Sits between the IF/LSU request logic and the memory interconnect. Drives busy_o toward the controller's drain and stall logic.

---
 rtl/mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// mem_port_arbiter
//   Shares the core's single memory port between instruction fetch (IF) and
//   the load/store unit (LSU). Requests use a req/gnt handshake toward memory,
//   responses come back in order via rvalid. A small owner FIFO remembers who
//   issued each accepted transaction so the response is routed to that side.
//   At most MAX_OUTSTANDING transactions may be accepted but unanswered.
//
//   Optional feature (macro MEM_ARB_STARVE_GUARD_EN):
//     When defined, a counter tracks consecutive LSU grants while IF waits.
//     After STARVE_LIMIT such grants, IF wins the next IDLE arbitration.
//     When undefined, the LSU always has priority.
//
// Ports:
//   clk_i, rstn_i            clock, asynchronous active-low reset
//   if_req_i / if_addr_i     fetch request and address
//   if_gnt_o                 fetch request accepted this cycle
//   if_rvalid_o/if_rdata_o   fetch response
//   lsu_req_i/we/be/addr/wdata  data request fields
//   lsu_gnt_o                data request accepted this cycle
//   lsu_rvalid_o/lsu_rdata_o data response (reads and writes)
//   mem_req_o/we/be/addr/wdata  request toward the memory interconnect
//   mem_gnt_i                memory accepted the request
//   mem_rvalid_i/mem_rdata_i memory response
//   busy_o                   transaction outstanding or a request held
//   protocol_err_o           response arrived with nothing outstanding
// ============================================================================
module mem_port_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned STARVE_LIMIT    = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    // instruction fetch
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    // load/store unit
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [3:0]  lsu_be_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o,
    // memory port
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    // status
    output logic        busy_o,
    output logic        protocol_err_o
);

    localparam int unsigned PTRW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNTW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD_IF  = 2'd1,
        HOLD_LSU = 2'd2
    } state_e;

    state_e state_q, state_d;

    // Owner FIFO: one bit per entry, 1 = LSU, 0 = IF.
    logic [MAX_OUTSTANDING-1:0] owner_q;
    logic [PTRW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0]            count_q;

    logic fifo_empty, fifo_full;
    logic push, pop;
    logic head_lsu;
    logic sel_valid, sel_lsu;
    logic grant;
    logic force_if;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNTW'(MAX_OUTSTANDING));
    assign head_lsu   = owner_q[rd_ptr_q];

    // A response is only consumed when something is outstanding; a stray
    // rvalid is dropped and flagged instead.
    assign pop  = mem_rvalid_i & ~fifo_empty;
    assign push = grant;

    // Pointers wrap modulo MAX_OUTSTANDING, which need not fill PTRW bits.
    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------------
    // Arbitration FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_lsu   = 1'b0;
        state_d   = IDLE;
        case (state_q)
            IDLE: begin
                // A pop this cycle frees a slot, so a full FIFO may still issue.
                if (!fifo_full || pop) begin
                    if (lsu_req_i && !(force_if && if_req_i)) begin
                        sel_valid = 1'b1;
                        sel_lsu   = 1'b1;
                    end else if (if_req_i) begin
                        sel_valid = 1'b1;
                        sel_lsu   = 1'b0;
                    end
                end
            end
            // Locked to the held requester until granted. If it drops its
            // request (a protocol violation) we fall back to IDLE rather than
            // issue a request nobody owns.
            HOLD_IF: begin
                sel_valid = if_req_i;
                sel_lsu   = 1'b0;
            end
            HOLD_LSU: begin
                sel_valid = lsu_req_i;
                sel_lsu   = 1'b1;
            end
            default: ;
        endcase
        if (sel_valid && !mem_gnt_i)
            state_d = sel_lsu ? HOLD_LSU : HOLD_IF;
    end

    // ------------------------------------------------------------------------
    // Request path (zero-cycle). Outputs are forced low while in reset so a
    // requester still asserting req cannot leak through during reset.
    // ------------------------------------------------------------------------
    always_comb begin
        mem_req_o   = rstn_i & sel_valid;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        if (mem_req_o) begin
            if (sel_lsu) begin
                mem_we_o    = lsu_we_i;
                mem_be_o    = lsu_be_i;
                mem_addr_o  = lsu_addr_i;
                mem_wdata_o = lsu_wdata_i;
            end else begin
                mem_be_o    = 4'hF;
                mem_addr_o  = if_addr_i;
            end
        end
    end

    assign grant     = mem_req_o & mem_gnt_i;
    assign if_gnt_o  = grant & ~sel_lsu;
    assign lsu_gnt_o = grant &  sel_lsu;

    // ------------------------------------------------------------------------
    // Response routing: head of the owner FIFO gets the response this cycle.
    // ------------------------------------------------------------------------
    assign if_rvalid_o    = pop & ~head_lsu;
    assign lsu_rvalid_o   = pop &  head_lsu;
    assign if_rdata_o     = if_rvalid_o  ? mem_rdata_i : 32'h0;
    assign lsu_rdata_o    = lsu_rvalid_o ? mem_rdata_i : 32'h0;
    assign protocol_err_o = rstn_i & mem_rvalid_i & fifo_empty;

    assign busy_o = (count_q != '0) | (state_q != IDLE);

    // ------------------------------------------------------------------------
    // Owner FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            owner_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                owner_q[wr_ptr_q] <= sel_lsu;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
            end
            if (pop)
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            // push and pop together (including when full) leave count as is
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Fetch starvation guard
    // ------------------------------------------------------------------------
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);

    logic [SCW-1:0] starve_q;

    assign force_if = (starve_q == SCW'(STARVE_LIMIT));

    // Counts LSU grants taken while IF is waiting; saturates at the limit
    // (reachable only through a granted HOLD_LSU).
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)
            starve_q <= '0;
        else if (!if_req_i || if_gnt_o)
            starve_q <= '0;
        else if (lsu_gnt_o && !force_if)
            starve_q <= starve_q + 1'b1;
    end
`else
    assign force_if = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MAX_OUTSTANDING=2, STARVE_LIMIT=4).
// Inputs change on the falling edge; combinational outputs are checked 1ns
// later, well before the next rising edge commits state.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o, if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        lsu_req_i, lsu_we_i;
    logic [3:0]  lsu_be_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i;
    logic        lsu_gnt_o, lsu_rvalid_o;
    logic [31:0] lsu_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o, protocol_err_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.MAX_OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
        .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o), .protocol_err_o(protocol_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance to the next falling edge (one full cycle later)
    task automatic nxt();
        @(negedge clk_i);
    endtask

    initial begin
        rstn_i = 1'b0;
        if_req_i = 0; if_addr_i = 0;
        lsu_req_i = 0; lsu_we_i = 0; lsu_be_i = 0; lsu_addr_i = 0; lsu_wdata_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        nxt(); nxt();
        #1;
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_perr", protocol_err_o, 0);
        nxt(); rstn_i = 1'b1;

        // ---- reset mid HOLD_LSU ----
        nxt(); lsu_req_i = 1; lsu_we_i = 1; lsu_be_i = 4'h3; lsu_addr_i = 32'h100; lsu_wdata_i = 32'h1234;
        #1;
        chk("hl_req", mem_req_o, 1);
        chk("hl_addr", mem_addr_o, 32'h100);
        chk("hl_be", mem_be_o, 4'h3);
        nxt(); #1;
        chk("hl_busy", busy_o, 1);
        rstn_i = 1'b0; #1;
        chk("rstm_req", mem_req_o, 0);
        chk("rstm_we", mem_we_o, 0);
        chk("rstm_addr", mem_addr_o, 0);
        chk("rstm_wdata", mem_wdata_o, 0);
        chk("rstm_busy", busy_o, 0);
        chk("rstm_lgnt", lsu_gnt_o, 0);
        nxt(); lsu_req_i = 0; lsu_we_i = 0; rstn_i = 1'b1;
        nxt(); if_req_i = 1; if_addr_i = 32'h40; mem_gnt_i = 1;
        #1;
        chk("if_gnt", if_gnt_o, 1);
        chk("if_be", mem_be_o, 4'hF);
        chk("if_addr", mem_addr_o, 32'h40);
        chk("if_wdata", mem_wdata_o, 0);
        chk("if_lgnt", lsu_gnt_o, 0);
        nxt(); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h11;
        #1;
        chk("if_rv", if_rvalid_o, 1);
        chk("if_rd", if_rdata_o, 32'h11);
        chk("if_lrv", lsu_rvalid_o, 0);
        nxt(); mem_rvalid_i = 0; #1;
        chk("idle_busy", busy_o, 0);

        // ---- simultaneous requests ----
        if_req_i = 1; if_addr_i = 32'h200;
        lsu_req_i = 1; lsu_we_i = 0; lsu_be_i = 4'hF; lsu_addr_i = 32'h300; mem_gnt_i = 1;
        #1;
        chk("sim_lgnt", lsu_gnt_o, 1);
        chk("sim_ignt", if_gnt_o, 0);
        chk("sim_addr", mem_addr_o, 32'h300);
        nxt(); lsu_req_i = 0; #1;
        chk("sim_ignt2", if_gnt_o, 1);
        chk("sim_addr2", mem_addr_o, 32'h200);
        nxt(); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h55; #1;
        chk("sim_lrv", lsu_rvalid_o, 1);
        chk("sim_lrd", lsu_rdata_o, 32'h55);
        chk("sim_irv0", if_rvalid_o, 0);
        chk("sim_ird0", if_rdata_o, 0);
        nxt(); mem_rdata_i = 32'h66; #1;
        chk("sim_irv", if_rvalid_o, 1);
        chk("sim_ird", if_rdata_o, 32'h66);
        nxt(); mem_rvalid_i = 0;

        // ---- hold rule ----
        lsu_req_i = 1; lsu_we_i = 1; lsu_be_i = 4'hF; lsu_addr_i = 32'h100; lsu_wdata_i = 32'hDEADBEEF;
        #1;
        chk("hold_req", mem_req_o, 1);
        chk("hold_we", mem_we_o, 1);
        chk("hold_lgnt0", lsu_gnt_o, 0);
        nxt(); if_req_i = 1; if_addr_i = 32'h400; #1;
        chk("hold_addr1", mem_addr_o, 32'h100);
        chk("hold_wdata", mem_wdata_o, 32'hDEADBEEF);
        chk("hold_ignt", if_gnt_o, 0);
        nxt(); #1;
        chk("hold_addr2", mem_addr_o, 32'h100);
        nxt(); mem_gnt_i = 1; #1;
        chk("hold_lgnt", lsu_gnt_o, 1);
        chk("hold_igntx", if_gnt_o, 0);
        chk("hold_addr3", mem_addr_o, 32'h100);
        nxt(); lsu_req_i = 0; lsu_we_i = 0; #1;
        chk("hold_igt", if_gnt_o, 1);
        chk("hold_iaddr", mem_addr_o, 32'h400);
        nxt(); if_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0; #1;
        chk("hold_lrv", lsu_rvalid_o, 1);
        nxt(); mem_rdata_i = 32'h77; #1;
        chk("hold_irv", if_rvalid_o, 1);
        chk("hold_ird", if_rdata_o, 32'h77);
        nxt(); mem_rvalid_i = 0;

        // ---- outstanding limit ----
        if_req_i = 1; if_addr_i = 32'h500; mem_gnt_i = 1; #1;
        chk("ol_g1", if_gnt_o, 1);
        nxt(); if_addr_i = 32'h504; #1;
        chk("ol_g2", if_gnt_o, 1);
        nxt(); if_addr_i = 32'h508; #1;
        chk("ol_full_req", mem_req_o, 0);
        chk("ol_full_gnt", if_gnt_o, 0);
        chk("ol_busy", busy_o, 1);
        nxt(); mem_rvalid_i = 1; mem_rdata_i = 32'h13; #1;
        chk("ol_rv1", if_rvalid_o, 1);
        chk("ol_rd1", if_rdata_o, 32'h13);
        chk("ol_popreq", mem_req_o, 1);
        chk("ol_popgnt", if_gnt_o, 1);
        nxt(); if_req_i = 0; mem_gnt_i = 0; mem_rdata_i = 32'h93; #1;
        chk("ol_rv2", if_rvalid_o, 1);
        chk("ol_rd2", if_rdata_o, 32'h93);
        nxt(); mem_rdata_i = 32'h99; #1;
        chk("ol_rv3", if_rvalid_o, 1);
        chk("ol_rd3", if_rdata_o, 32'h99);
        nxt(); mem_rvalid_i = 0; #1;
        chk("ol_busy0", busy_o, 0);

        // ---- mixed routing ----
        if_req_i = 1; if_addr_i = 32'h600; mem_gnt_i = 1; #1;
        chk("mx_igt", if_gnt_o, 1);
        nxt(); if_req_i = 0; lsu_req_i = 1; lsu_we_i = 0; lsu_addr_i = 32'h700; #1;
        chk("mx_lgt", lsu_gnt_o, 1);
        chk("mx_we", mem_we_o, 0);
        nxt(); lsu_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hAAAA; #1;
        chk("mx_irv", if_rvalid_o, 1);
        chk("mx_ird", if_rdata_o, 32'hAAAA);
        chk("mx_lrv0", lsu_rvalid_o, 0);
        chk("mx_lrd0", lsu_rdata_o, 0);
        nxt(); mem_rdata_i = 32'hBBBB; #1;
        chk("mx_lrv", lsu_rvalid_o, 1);
        chk("mx_lrd", lsu_rdata_o, 32'hBBBB);
        chk("mx_irv0", if_rvalid_o, 0);
        chk("mx_ird0", if_rdata_o, 0);
        nxt(); mem_rdata_i = 32'hEE; #1;

        // ---- stray response with empty FIFO ----
        chk("pe_pulse", protocol_err_o, 1);
        chk("pe_irv", if_rvalid_o, 0);
        chk("pe_lrv", lsu_rvalid_o, 0);
        nxt(); mem_rvalid_i = 0; #1;
        chk("pe_clear", protocol_err_o, 0);
        chk("pe_busy", busy_o, 0);

        // ---- starvation pattern: both request, memory always grants ----
        if_req_i = 1; if_addr_i = 32'h800;
        lsu_req_i = 1; lsu_we_i = 0; lsu_addr_i = 32'h900; mem_gnt_i = 1;
        for (int i = 0; i < 10; i++) begin
            logic exp_if;
            exp_if = GUARD && ((i % 5) == 4);
            #1;
            chk($sformatf("sv_if%0d", i), if_gnt_o, exp_if);
            chk($sformatf("sv_lsu%0d", i), lsu_gnt_o, !exp_if);
            // keep one transaction in flight so the FIFO never fills
            nxt(); mem_rvalid_i = 1;
        end
        if_req_i = 0; lsu_req_i = 0; mem_gnt_i = 0;
        nxt(); mem_rvalid_i = 0; #1;
        chk("sv_busy0", busy_o, 0);
        chk("sv_perr0", protocol_err_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // global watchdog in case a step ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
